// File: rtl/bcp_pkg.sv
// Shared definitions for the BCP clause initialization path.
// Holds the check-unit count, address width, the clause record layout and
// the loader state encoding used by clause_init_loader and its buffer.
package bcp_pkg;

  localparam int unsigned BCP_CHECK_NUM = 8;
  localparam int unsigned MEM_ADDR_W    = 3;
  localparam int unsigned REC_W         = 24;
  localparam int unsigned CNT_W         = 4;   // holds 0..BCP_CHECK_NUM
  localparam int unsigned TMO_W         = 8;

  // Clause record as carried on rec_data / initial_mem.
  typedef struct packed {
    logic [7:0] clause_type;
    logic [7:0] clause_mask;
    logic [7:0] clause_size;
  } clause_rec_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    REQ  = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4
  } loader_state_t;

  // Even parity (XOR reduction) of one record word.
  function automatic logic rec_parity(input clause_rec_t rec);
    return ^rec;
  endfunction

endpackage

// File: rtl/clause_init_buffer.sv
// Eight-entry clause record store: indexed synchronous write, combinational
// read. Contents are not reset; every entry is written before it is read.
// Ports:
//   clock      - clock
//   wr_en      - write strobe
//   wr_addr    - write index 0..7
//   wr_data    - record to store
//   rd_addr    - read index 0..7
//   rd_data_c  - record at rd_addr (combinational)
module clause_init_buffer
  import bcp_pkg::*;
(
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [MEM_ADDR_W-1:0] wr_addr,
  input  logic [REC_W-1:0]      wr_data,
  input  logic [MEM_ADDR_W-1:0] rd_addr,
  output logic [REC_W-1:0]      rd_data_c
);

  clause_rec_t mem [BCP_CHECK_NUM];

  // Write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= clause_rec_t'(wr_data);
    end
  end

  // Read port
  assign rd_data_c = REC_W'(mem[rd_addr]);

endmodule

// File: rtl/clause_init_loader.sv
// Clause init loader: collects up to eight clause records from an upstream
// valid/ready stream, asks the BCP controller to enter its initial state,
// streams the records to check units 0..count-1, then waits (bounded by an
// 8-bit timeout) for initial_finish and reports done or error.
// Optional feature: define INIT_PARITY_EN to add the initial_parity output.
// Ports:
//   clock, reset          - clock; synchronous active-low reset
//   load_start            - opens a session (honoured in IDLE only)
//   rec_valid/rec_data/rec_last/rec_ready - upstream record stream
//   system_initial_signal - one-cycle initial-state request to BCP controller
//   initial_mem/addr/we   - record word, check-unit index, valid strobe
//   initial_finish        - BCP controller finished (honoured in WAIT only)
//   load_done/load_error  - one-cycle session result pulses
//   initial_parity        - (INIT_PARITY_EN) even parity of initial_mem
module clause_init_loader
  import bcp_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  rec_valid,
  input  logic [REC_W-1:0]      rec_data,
  input  logic                  rec_last,
  output logic                  rec_ready,
  output logic                  system_initial_signal,
  output logic [REC_W-1:0]      initial_mem,
  output logic [MEM_ADDR_W-1:0] initial_addr,
  output logic                  initial_we,
  input  logic                  initial_finish,
  output logic                  load_done,
  output logic                  load_error
`ifdef INIT_PARITY_EN
  ,
  output logic                  initial_parity
`endif
);

  // Last counter value before the timeout would reach 255.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);

  loader_state_t         state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [MEM_ADDR_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0]      timeout_q, timeout_d;
  logic                  truncated_q, truncated_d;

  logic                  rec_ready_d;
  logic                  sis_d;
  logic [REC_W-1:0]      initial_mem_d;
  logic [MEM_ADDR_W-1:0] initial_addr_d;
  logic                  initial_we_d;
  logic                  load_done_d;
  logic                  load_error_d;

  logic                  xfer_c;
  logic [REC_W-1:0]      rd_data_c;

  assign xfer_c = (state_q == FILL) && rec_valid && rec_ready;

  // Record store; read index follows the next idx so initial_mem can be registered.
  clause_init_buffer u_buffer (
    .clock     (clock),
    .wr_en     (xfer_c),
    .wr_addr   (count_q[MEM_ADDR_W-1:0]),
    .wr_data   (rec_data),
    .rd_addr   (idx_d),
    .rd_data_c (rd_data_c)
  );

  // Next state, counters, and next values of the registered outputs
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    idx_d          = idx_q;
    timeout_d      = timeout_q;
    truncated_d    = truncated_q;
    rec_ready_d    = 1'b0;
    sis_d          = 1'b0;
    initial_mem_d  = '0;
    initial_addr_d = '0;
    initial_we_d   = 1'b0;
    load_done_d    = 1'b0;
    load_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        count_d   = '0;
        idx_d     = '0;
        timeout_d = '0;
        if (load_start) begin
          state_d     = FILL;
          truncated_d = 1'b0;
        end
      end

      FILL: begin
        if (xfer_c) begin
          count_d = count_q + CNT_W'(1);
          if (rec_last) begin
            state_d = REQ;
          end else if (count_q == CNT_W'(BCP_CHECK_NUM - 1)) begin
            state_d     = REQ;
            truncated_d = 1'b1;
          end
        end
      end

      REQ: begin
        state_d = SEND;
        idx_d   = '0;
      end

      SEND: begin
        if ({1'b0, idx_q} == count_q - CNT_W'(1)) begin
          state_d   = WAIT;
          timeout_d = '0;
        end else begin
          idx_d = idx_q + MEM_ADDR_W'(1);
        end
      end

      WAIT: begin
        // initial_finish takes priority over an expiring timeout
        if (initial_finish) begin
          state_d      = IDLE;
          load_done_d  = !truncated_q;
          load_error_d = truncated_q;
        end else if (timeout_q == TMO_LAST) begin
          state_d      = IDLE;
          load_error_d = 1'b1;
        end else begin
          timeout_d = timeout_q + TMO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    rec_ready_d = (state_d == FILL) && (count_d < CNT_W'(BCP_CHECK_NUM));
    sis_d       = (state_d == REQ);
    if (state_d == SEND) begin
      initial_we_d   = 1'b1;
      initial_addr_d = idx_d;
      initial_mem_d  = rd_data_c;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q               <= IDLE;
      count_q               <= '0;
      idx_q                 <= '0;
      timeout_q             <= '0;
      truncated_q           <= 1'b0;
      rec_ready             <= 1'b0;
      system_initial_signal <= 1'b0;
      initial_mem           <= '0;
      initial_addr          <= '0;
      initial_we            <= 1'b0;
      load_done             <= 1'b0;
      load_error            <= 1'b0;
    end else begin
      state_q               <= state_d;
      count_q               <= count_d;
      idx_q                 <= idx_d;
      timeout_q             <= timeout_d;
      truncated_q           <= truncated_d;
      rec_ready             <= rec_ready_d;
      system_initial_signal <= sis_d;
      initial_mem           <= initial_mem_d;
      initial_addr          <= initial_addr_d;
      initial_we            <= initial_we_d;
      load_done             <= load_done_d;
      load_error            <= load_error_d;
    end
  end

`ifdef INIT_PARITY_EN
  logic initial_parity_d;

  // Parity of the word being presented; zero when no word is presented
  always_comb begin
    initial_parity_d = 1'b0;
    if (initial_we_d) begin
      initial_parity_d = rec_parity(clause_rec_t'(initial_mem_d));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      initial_parity <= 1'b0;
    end else begin
      initial_parity <= initial_parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_clause_init_loader.sv
// Directed testbench for clause_init_loader: a cycle-by-cycle vector table
// for normal sessions plus hand-written truncation, timeout, priority and
// reset sequences.
module tb_clause_init_loader;

  logic        clock;
  logic        reset;
  logic        load_start;
  logic        rec_valid;
  logic [23:0] rec_data;
  logic        rec_last;
  logic        rec_ready;
  logic        system_initial_signal;
  logic [23:0] initial_mem;
  logic [2:0]  initial_addr;
  logic        initial_we;
  logic        initial_finish;
  logic        load_done;
  logic        load_error;
`ifdef INIT_PARITY_EN
  logic        initial_parity;
`endif

  clause_init_loader dut (
    .clock                 (clock),
    .reset                 (reset),
    .load_start            (load_start),
    .rec_valid             (rec_valid),
    .rec_data              (rec_data),
    .rec_last              (rec_last),
    .rec_ready             (rec_ready),
    .system_initial_signal (system_initial_signal),
    .initial_mem           (initial_mem),
    .initial_addr          (initial_addr),
    .initial_we            (initial_we),
    .initial_finish        (initial_finish),
    .load_done             (load_done),
    .load_error            (load_error)
`ifdef INIT_PARITY_EN
    ,
    .initial_parity        (initial_parity)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        rr;
    logic        sis;
    logic        we;
    logic [2:0]  addr;
    logic [23:0] mem;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    logic        ls;
    logic        rv;
    logic [23:0] rd;
    logic        rl;
    logic        fin;
    out_t        exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic out_t ov(input logic rr, input logic sis, input logic we,
                              input logic [2:0] addr, input logic [23:0] mem,
                              input logic done, input logic err);
    out_t o;
    o.rr = rr; o.sis = sis; o.we = we; o.addr = addr; o.mem = mem;
    o.done = done; o.err = err;
    return o;
  endfunction

  function automatic vec_t mk(input logic ls, input logic rv, input logic [23:0] rd,
                              input logic rl, input logic fin, input out_t exp);
    vec_t v;
    v.ls = ls; v.rv = rv; v.rd = rd; v.rl = rl; v.fin = fin; v.exp = exp;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ls, input logic rv, input logic [23:0] rd,
                       input logic rl, input logic fin);
    load_start = ls; rec_valid = rv; rec_data = rd; rec_last = rl; initial_finish = fin;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {rec_ready, system_initial_signal, initial_we, initial_addr, initial_mem,
           load_done, load_error};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got rr=%b sis=%b we=%b addr=%0d mem=%h done=%b err=%b, want rr=%b sis=%b we=%b addr=%0d mem=%h done=%b err=%b",
               name, act.rr, act.sis, act.we, act.addr, act.mem, act.done, act.err,
               exp.rr, exp.sis, exp.we, exp.addr, exp.mem, exp.done, exp.err);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // load_start, one record flagged last, request, single word, enter WAIT.
  task automatic one_record_session(input string name, input logic [23:0] data);
    drive(1, 0, 0, 0, 0); step(); check({name, "_start"}, ov(1,0,0,0,0,0,0));
    drive(0, 1, data, 1, 0); step(); check({name, "_req"}, ov(0,1,0,0,0,0,0));
    drive(0, 0, 0, 0, 0); step(); check({name, "_we0"}, ov(0,0,1,0,data,0,0));
    step(); check({name, "_wait"}, ov(0,0,0,0,0,0,0));
  endtask

  vec_t vecs[$];
  out_t zero;

  initial begin
    zero = ov(0,0,0,0,0,0,0);
    reset = 1'b0;
    drive(1, 1, 24'hFFFFFF, 1, 1);

    // Reset holds everything at zero even with active inputs
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold_%0d", i), zero);
    end
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    check("reset_release", zero);

    // Three-record session with ignored finish/load_start in the wrong states
    vecs.push_back(mk(1,0,24'h000000,0,0, ov(1,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,1,24'h010F03,0,0, ov(1,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,1,24'h020302,0,1, ov(1,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,1,24'h03FF08,1,0, ov(0,1,0,0,24'h000000,0,0)));
    vecs.push_back(mk(1,0,24'h000000,0,1, ov(0,0,1,0,24'h010F03,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,1,1,24'h020302,0,0)));
    vecs.push_back(mk(1,0,24'h000000,0,0, ov(0,0,1,2,24'h03FF08,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(1,0,24'h000000,0,0, ov(0,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,1, ov(0,0,0,0,24'h000000,1,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,0,0,24'h000000,0,0)));
    // Single-record session with an idle bubble in FILL
    vecs.push_back(mk(1,0,24'h000000,0,0, ov(1,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(1,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,1,24'hABCDEF,1,0, ov(0,1,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,1,0,24'hABCDEF,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,0,0,24'h000000,0,0)));
    vecs.push_back(mk(0,0,24'h000000,0,1, ov(0,0,0,0,24'h000000,1,0)));
    vecs.push_back(mk(0,0,24'h000000,0,0, ov(0,0,0,0,24'h000000,0,0)));

    foreach (vecs[i]) begin
      drive(vecs[i].ls, vecs[i].rv, vecs[i].rd, vecs[i].rl, vecs[i].fin);
      step();
      check($sformatf("vec_%0d", i), vecs[i].exp);
    end
    drive(0, 0, 0, 0, 0);

    // Truncation: nine records offered without rec_last, only eight taken
    drive(1, 0, 0, 0, 0); step(); check("trunc_start", ov(1,0,0,0,0,0,0));
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 24'h100000 + 24'(i), 0, 0);
      step();
      check($sformatf("trunc_acc_%0d", i), ov((i < 7), (i == 7), 0, 0, 0, 0, 0));
    end
    drive(0, 1, 24'h1000FF, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("trunc_send_%0d", k), ov(0,0,1,3'(k),24'h100000 + 24'(k),0,0));
    end
    drive(0, 0, 0, 0, 0);
    step(); check("trunc_wait", zero);
    drive(0, 0, 0, 0, 1); step(); check("trunc_finish_err", ov(0,0,0,0,0,0,1));
    drive(0, 0, 0, 0, 0); step(); check("trunc_after", zero);

    // Timeout: no finish, load_error 255 cycles after the first WAIT cycle
    one_record_session("tmo", 24'h000001);
    begin
      int n;
      int early;
      n = 0;
      early = 0;
      while (!load_error && n < 300) begin
        step();
        n++;
        if (load_done) early++;
      end
      check_int("tmo_cycles", n, 255);
      check_int("tmo_no_done", early, 0);
    end
    check("tmo_err_pulse", ov(0,0,0,0,0,0,1));
    step(); check("tmo_idle", zero);
    drive(1, 0, 0, 0, 0); step(); check("tmo_restart", ov(1,0,0,0,0,0,0));
    drive(0, 0, 0, 0, 0);
    reset = 1'b0; step(); check("tmo_reset", zero);
    reset = 1'b1;

    // Finish on the cycle the timeout would expire: finish wins
    one_record_session("prio", 24'h00AA55);
    begin
      int early;
      early = 0;
      for (int k = 0; k < 254; k++) begin
        step();
        if (load_done || load_error) early++;
      end
      check_int("prio_no_early_pulse", early, 0);
    end
    drive(0, 0, 0, 0, 1); step(); check("prio_finish_wins", ov(0,0,0,0,0,1,0));
    drive(0, 0, 0, 0, 0); step(); check("prio_after", zero);

    // Reset in the middle of SEND at idx 4, then a fresh session from addr 0
    drive(1, 0, 0, 0, 0); step(); check("rst_start", ov(1,0,0,0,0,0,0));
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 24'h600000 + 24'(i), (i == 5), 0);
      step();
      check($sformatf("rst_acc_%0d", i), ov((i < 5), (i == 5), 0, 0, 0, 0, 0));
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rst_send_%0d", k), ov(0,0,1,3'(k),24'h600000 + 24'(k),0,0));
    end
    reset = 1'b0; step(); check("rst_mid_send", zero);
    reset = 1'b1; step(); check("rst_idle", zero);
    one_record_session("rst_new", 24'h5A5A5A);
    drive(0, 0, 0, 0, 1); step(); check("rst_new_done", ov(0,0,0,0,0,1,0));
    drive(0, 0, 0, 0, 0); step();

`ifdef INIT_PARITY_EN
    // Parity of presented words
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 24'h000007, 0, 0); step();
    drive(0, 1, 24'h000003, 1, 0); step();
    check_int("par_idle", int'(initial_parity), 0);
    drive(0, 0, 0, 0, 0); step();
    check("par_we0", ov(0,0,1,0,24'h000007,0,0));
    check_int("par_0x000007", int'(initial_parity), 1);
    step();
    check("par_we1", ov(0,0,1,1,24'h000003,0,0));
    check_int("par_0x000003", int'(initial_parity), 0);
    drive(0, 0, 0, 0, 1); step(); step();
    drive(0, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clause_init_loader.md
CLAUSE_INIT_LOADER -- requirements
Module: clause_init_loader

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all logic on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have port: load_start  in  1  one-cycle pulse; opens a load session.
REQ-004 SHALL have port: rec_valid  in  1  upstream clause record valid.
REQ-005 SHALL have port: rec_data  in  24  record: [23:16] clause_type, [15:8] clause_mask, [7:0] clause_size.
REQ-006 SHALL have port: rec_last  in  1  qualifies rec_data as the final record of the session.
REQ-007 SHALL have port: rec_ready  out  1  loader accepts a record; transfer when rec_valid&&rec_ready.
REQ-008 SHALL have port: system_initial_signal  out  1  one-cycle request to the BCP controller to enter initial state.
REQ-009 SHALL have port: initial_mem  out  24  record word to the BCP controller.
REQ-010 SHALL have port: initial_addr  out  3  check-unit index 0..7.
REQ-011 SHALL have port: initial_we  out  1  initial_mem/initial_addr valid this cycle.
REQ-012 SHALL have port: initial_finish  in  1  BCP controller has completed initialization.
REQ-013 SHALL have port: load_done  out  1  one-cycle pulse on successful session end.
REQ-014 SHALL have port: load_error  out  1  one-cycle pulse on timeout or truncation.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, REQ, SEND, WAIT.
REQ-016 IDLE: rec_ready=0; load_start -> FILL with count=0, truncated=0.
REQ-017 FILL: rec_ready=1 while count<8; each transfer stores rec_data at buffer[count], count+1.
REQ-018 FILL -> REQ on the cycle a transfer has rec_last=1, or when the 8th record is accepted.
REQ-019 8th record accepted with rec_last=0 SHALL set truncated=1; rec_ready=0 from the next cycle.
REQ-020 REQ: system_initial_signal=1 for exactly one cycle, then SEND.
REQ-021 SEND: initial_we=1 on count consecutive cycles, initial_addr=idx, initial_mem=buffer[idx], idx 0..count-1; after last word -> WAIT.
REQ-022 WAIT: 8-bit timeout counter cleared on entry, +1 per cycle; initial_finish=1 -> IDLE with load_done pulse (load_error instead if truncated).
REQ-023 Timeout reaching 255 without initial_finish SHALL pulse load_error and return to IDLE.
REQ-024 initial_finish outside WAIT and load_start outside IDLE SHALL be ignored.
REQ-025 initial_finish and timeout in the same cycle: initial_finish wins.
REQ-026 initial_mem/initial_addr SHALL be 0 whenever initial_we=0.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, count=0, idx=0, timeout=0, truncated=0, all outputs 0, mid-session included.
REQ-028 Buffer contents SHALL need no reset.

Configuration
REQ-029 Macro INIT_PARITY_EN defined: extra output initial_parity (1 bit) = even parity (XOR) of initial_mem, valid with initial_we, else 0.
REQ-030 INIT_PARITY_EN undefined: port and logic absent; all other behaviour identical.

Structure
REQ-031 Shared package bcp_pkg SHALL hold BCP_CHECK_NUM=8, MEM_ADDR_W=3, clause_rec_t (type/mask/size bytes), loader state enum.
REQ-032 Sub-module clause_init_buffer (8x24 write-indexed storage, combinational read) SHALL be instantiated once.

Verification
REQ-033 load_start; 3 records 0x010F03,0x020302,0x03FF08 (last on 3rd) -> one system_initial_signal; we on addr 0,1,2 with those words; finish -> load_done.
REQ-034 9 records offered without rec_last -> only 8 accepted, rec_ready low after 8th, addr 0..7 sent, finish -> load_error, no load_done.
REQ-035 No initial_finish after SEND -> load_error exactly 255 cycles after WAIT entry, state IDLE.
REQ-036 reset=0 during SEND idx=4 -> next cycle all outputs 0; new session then starts at addr 0.
REQ-037 load_start during WAIT and initial_finish during FILL -> no effect; session completes normally.
REQ-038 INIT_PARITY_EN: word 0x000007 -> initial_parity=1; 0x000003 -> 0.
